// File: rtl/calculator_seq.sv
// -----------------------------------------------------------------------------
// calculator_seq
//
// Sequential calculator ALU with a start/busy/done handshake. Uses the same
// opcode map and the same 2*Nbits result format as the combinational
// calculator. Divide and modulo run on a restoring divider that takes one
// iteration per cycle. Results and status flags are registered and are held
// until the next done pulse.
//
// Parameter:
//   Nbits        operand width (>= 2); result width is 2*Nbits
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset; aborts any operation in flight
//   start        request, sampled only in IDLE
//   op_select    operation code, captured with start
//   operand1     first operand (unsigned), captured with start
//   operand2     second operand (unsigned), captured with start
//   busy         high while in EXEC or DIV
//   done         one-cycle pulse; resultado and flags are valid from here
//   resultado    registered 2*Nbits result
//   zero         resultado == 0
//   carry        ADD carry / SUB borrow, 0 for every other op
//   div_by_zero  DIV or MOD with operand2 == 0
//   invalid_op   op_select in 1010..1111
//
// Optional build macro:
//   CALC_MUL_SEQ_EN  when defined, MUL runs as a shift-add multiplier in the
//                    iterative state (Nbits iterations, same latency as DIV).
//                    When undefined, MUL is a single-cycle product on the
//                    EXEC path. Results are identical either way.
// -----------------------------------------------------------------------------
module calculator_seq #(
  parameter int Nbits = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         op_select,
  input  logic [Nbits-1:0]   operand1,
  input  logic [Nbits-1:0]   operand2,
  output logic               busy,
  output logic               done,
  output logic [2*Nbits-1:0] resultado,
  output logic               zero,
  output logic               carry,
  output logic               div_by_zero,
  output logic               invalid_op
);

  localparam int W  = 2 * Nbits;
  localparam int CW = $clog2(Nbits + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  // The iterative state spends Nbits cycles iterating and one further cycle
  // loading the outputs, so the counter must reach Nbits.
  localparam logic [CW-1:0] LAST_ITER = CW'(Nbits);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    DONE
  } state_t;

  state_t state;

  // Operands captured at an accepted start.
  logic [3:0]       op_reg;
  logic [Nbits-1:0] a_reg;
  logic [Nbits-1:0] b_reg;

  // Iterative datapath. For the divider work_hi is the partial remainder and
  // work_lo shifts the dividend out while the quotient bits shift in. For
  // the shift-add multiplier work_hi is the upper product half and work_lo
  // shifts the multiplier out while the lower product bits shift in.
  logic [Nbits-1:0] work_hi;
  logic [Nbits-1:0] work_lo;
  logic [CW-1:0]    iter_cnt;

  // ---------------------------------------------------------------------------
  // Decide at start time whether the operation needs the iterative state.
  // Divide by zero never enters it: it is resolved on the EXEC path.
  // ---------------------------------------------------------------------------
  logic             start_iter;
  logic [Nbits-1:0] start_lo;

  always_comb begin
    start_iter = ((op_select == OP_DIV) || (op_select == OP_MOD)) &&
                 (operand2 != '0);
    start_lo   = operand1;
`ifdef CALC_MUL_SEQ_EN
    if (op_select == OP_MUL) begin
      start_iter = 1'b1;
      start_lo   = operand2;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // One restoring-divider iteration.
  // The shifted remainder is always below 2*divisor, so when it is at least
  // the divisor the difference fits in Nbits and plain modular subtraction
  // on the low Nbits gives the exact new remainder.
  // ---------------------------------------------------------------------------
  logic [Nbits:0]   div_shift;
  logic             div_ge;
  logic [Nbits-1:0] div_diff;
  logic [Nbits-1:0] hi_next;
  logic [Nbits-1:0] lo_next;

  assign div_shift = {work_hi, work_lo[Nbits-1]};
  assign div_ge    = div_shift >= {1'b0, b_reg};
  assign div_diff  = div_shift[Nbits-1:0] - b_reg;

`ifdef CALC_MUL_SEQ_EN
  // One shift-add multiplier iteration: add the multiplicand into the upper
  // half when the current multiplier bit is set, then shift the whole
  // {carry, upper, lower} product right by one.
  logic [Nbits:0] mul_sum;
  assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_reg} : '0);
`endif

  always_comb begin
    hi_next = div_ge ? div_diff : div_shift[Nbits-1:0];
    lo_next = {work_lo[Nbits-2:0], div_ge};
`ifdef CALC_MUL_SEQ_EN
    if (op_reg == OP_MUL) begin
      hi_next = mul_sum[Nbits:1];
      lo_next = {mul_sum[0], work_lo[Nbits-1:1]};
    end
`endif
  end

  // Result when the iterative state finishes.
  logic [W-1:0] iter_res;

  always_comb begin
    if (op_reg == OP_MOD) begin
      iter_res = {{Nbits{1'b0}}, work_hi};
    end else begin
      iter_res = {{Nbits{1'b0}}, work_lo};
    end
`ifdef CALC_MUL_SEQ_EN
    if (op_reg == OP_MUL) begin
      iter_res = {work_hi, work_lo};
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Single-cycle EXEC datapath, working from the captured operands.
  // ---------------------------------------------------------------------------
  logic [Nbits:0] sum_ext;
  logic [Nbits:0] diff_ext;
  logic [W-1:0]   a_ext;
  logic [W-1:0]   exec_res;
  logic           exec_carry;
  logic           exec_dbz;
  logic           exec_inv;

  assign sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
  // Bit Nbits of the (Nbits+1)-bit difference is both the sign of the true
  // difference and the borrow.
  assign diff_ext = {1'b0, a_reg} - {1'b0, b_reg};
  assign a_ext    = {{Nbits{1'b0}}, a_reg};

  always_comb begin
    exec_res   = '0;
    exec_carry = 1'b0;
    exec_dbz   = 1'b0;
    exec_inv   = 1'b0;
    case (op_reg)
      OP_ADD: begin
        exec_res   = {{(Nbits-1){1'b0}}, sum_ext};
        exec_carry = sum_ext[Nbits];
      end
      OP_SUB: begin
        exec_res   = {{(Nbits-1){diff_ext[Nbits]}}, diff_ext};
        exec_carry = diff_ext[Nbits];
      end
      OP_MUL: begin
`ifdef CALC_MUL_SEQ_EN
        exec_res = '0;
`else
        exec_res = a_ext * {{Nbits{1'b0}}, b_reg};
`endif
      end
      // DIV/MOD only reach EXEC with a zero divisor.
      OP_DIV, OP_MOD: begin
        if (b_reg == '0) begin
          exec_res = '1;
          exec_dbz = 1'b1;
        end
      end
      OP_AND: exec_res = {{Nbits{1'b0}}, a_reg & b_reg};
      OP_OR:  exec_res = {{Nbits{1'b0}}, a_reg | b_reg};
      OP_XOR: exec_res = {{Nbits{1'b0}}, a_reg ^ b_reg};
      // Shifts by at least the operand width yield 0 by shift semantics.
      OP_SHL: exec_res = a_ext << b_reg;
      OP_SHR: exec_res = {{Nbits{1'b0}}, a_reg >> b_reg};
      default: begin
        exec_res = '0;
        exec_inv = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // busy and done are set on the transitions into their states, so they are
  // aligned with the state register rather than decoded from it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      iter_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      resultado   <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      div_by_zero <= 1'b0;
      invalid_op  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_reg   <= op_select;
            a_reg    <= operand1;
            b_reg    <= operand2;
            work_hi  <= '0;
            work_lo  <= start_lo;
            iter_cnt <= '0;
            busy     <= 1'b1;
            state    <= start_iter ? DIV : EXEC;
          end
        end

        EXEC: begin
          resultado   <= exec_res;
          zero        <= (exec_res == '0);
          carry       <= exec_carry;
          div_by_zero <= exec_dbz;
          invalid_op  <= exec_inv;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end

        DIV: begin
          if (iter_cnt == LAST_ITER) begin
            resultado   <= iter_res;
            zero        <= (iter_res == '0);
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
            invalid_op  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            work_hi  <= hi_next;
            work_lo  <= lo_next;
            iter_cnt <= iter_cnt + CW'(1);
          end
        end

        DONE: begin
          // A start seen here is dropped; a new op needs IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/calculator_seq.md
Name: calculator_seq

Overview:
Sequential, parametrised successor to the combinational calculator ALU. It keeps the same opcode map and the same 2*Nbits result format. Operations start with a start/busy/done handshake. Divide and modulo run on a multi-cycle restoring divider, and results and status flags are registered. It sits between the operand/selector input logic and the result display/register path.

Parameters:
Nbits, 4, operand width in bits (min 2); result width is 2*Nbits.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
op_select  input  4  operation code, captured with start.
operand1  input  Nbits  first operand, unsigned, captured with start.
operand2  input  Nbits  second operand, unsigned, captured with start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse; resultado and flags are valid from this cycle.
resultado  output  2*Nbits  registered result, held until the next done.
zero  output  1  resultado == 0, updated with done.
carry  output  1  carry out for ADD, borrow for SUB, 0 for all other ops.
div_by_zero  output  1  DIV or MOD with operand2 == 0.
invalid_op  output  1  op_select is in the range 1010..1111.

Behaviour:
- Reset (reset_n low, asynchronous): every output is 0, the FSM goes to IDLE, and any operation in flight is aborted with no done.
- FSM states: IDLE, EXEC, DIV, DONE.
- IDLE: when start=1, capture op_select, operand1 and operand2. Go to DIV if the op is DIV or MOD and operand2 != 0; otherwise go to EXEC.
- EXEC: compute in one cycle, then go to DONE.
- DIV: run one restoring iteration per cycle for exactly Nbits cycles, then go to DONE.
- DONE: done=1 for this one cycle, outputs are loaded, then return to IDLE.
- Latency, with start sampled at edge t:
  - single-cycle ops: done at edge t+2;
  - DIV/MOD: done at edge t+Nbits+2.
- busy is high in EXEC and DIV and low in IDLE and DONE.
- start while not in IDLE is ignored: no queueing, no restart.
- Opcodes and results (all unsigned):
  - 0000 ADD: zero-extended sum; bit Nbits holds the carry.
  - 0001 SUB: operand1-operand2 in two's complement, sign-extended to 2*Nbits; carry = borrow.
  - 0010 MUL: full 2*Nbits product.
  - 0011 DIV: quotient, zero-extended.
  - 0100 MOD: remainder, zero-extended.
  - 0101 AND, 0110 OR, 0111 XOR: zero-extended.
  - 1000 SHL: zext(operand1) << operand2 in 2*Nbits; shift amount >= 2*Nbits gives 0.
  - 1001 SHR: logical operand1 >> operand2; shift amount >= Nbits gives 0.
  - 1010..1111: resultado=0, invalid_op=1, handled on the EXEC path.
- Divide by zero: no DIV state. resultado = all ones, div_by_zero=1, single-cycle latency.
- div_by_zero, invalid_op, carry and zero are all updated at done and held until the next done.
- start asserted in the same cycle as the DONE state is ignored; a new op needs IDLE.

Optional Feature:
- Macro: CALC_MUL_SEQ_EN.
- Defined: MUL uses a shift-add multiplier in the DIV-style iterative state (shared counter, Nbits cycles). MUL latency becomes done at t+Nbits+2 and busy is held throughout.
- Undefined: MUL is a single-cycle combinational product on the EXEC path, done at t+2.
- Results are identical either way.

Test Plan:
1. Reset, then ADD 5+3 -> resultado=8'h08, carry=0, done at t+2. ADD 15+1 -> 8'h10, carry=1.
2. SUB 3-1 -> 8'h02, carry=0. SUB 3-5 -> 8'hFE, carry=1.
3. DIV 14/2 -> 8'h07, done exactly at t+6, busy high for 5 cycles. A second start pulsed while busy is ignored. Then MOD 15%2 -> 8'h01.
4. DIV 7/0 -> 8'hFF, div_by_zero=1, done at t+2. Next op ADD 1+1 -> div_by_zero=0, resultado=8'h02.
5. MUL 15*3 -> 8'h2D, done at t+2, or t+6 with CALC_MUL_SEQ_EN. SHL 14<<2 -> 8'h38. SHR 14>>2 -> 8'h03. SHL 1<<9 -> 8'h00, zero=1.
6. Pull reset_n low mid-DIV -> all outputs 0 immediately, no done pulse, FSM back in IDLE. Then opcode 1100 -> resultado=0, invalid_op=1, zero=1.
